// File: rtl/odo_sbox_lanes.sv
// Multi-lane Odo S-box: LANES parallel W-bit substitutions from a double-buffered,
// runtime-loadable table. Optional second output stage under `ODO_SBOX_OREG_EN.
module odo_sbox_lanes #(
    parameter int unsigned W     = 6,
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld_valid,
    input  logic [W-1:0]       ld_data,
    input  logic               swap,
    output logic               tbl_valid,
    output logic               ld_done,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] out_data
);

    localparam int unsigned Depth = 1 << W;

    logic [W-1:0]       bank0_q [Depth];
    logic [W-1:0]       bank1_q [Depth];
    logic               bank_sel_q, bank_sel_d;
    logic [W-1:0]       ld_addr_q, ld_addr_d;
    logic               ld_done_q, ld_done_d;
    logic               tbl_valid_q, tbl_valid_d;
    logic               load_full;
    logic               in_fire;
    logic [LANES*W-1:0] lookup;

    // Table storage has no reset; only the control state does.
    always_ff @(posedge clk) begin
        if (!rst && ld_valid) begin
            if (bank_sel_q) begin
                bank0_q[ld_addr_q] <= ld_data;
            end else begin
                bank1_q[ld_addr_q] <= ld_data;
            end
        end
    end

    // The write of the last entry counts as completion in time for a same-cycle swap.
    always_comb begin
        load_full   = ld_done_q || (ld_valid && (&ld_addr_q));
        bank_sel_d  = bank_sel_q;
        ld_addr_d   = ld_valid ? ld_addr_q + W'(1) : ld_addr_q;
        ld_done_d   = load_full;
        tbl_valid_d = tbl_valid_q;
        if (swap && load_full) begin
            bank_sel_d  = ~bank_sel_q;
            ld_addr_d   = '0;
            ld_done_d   = 1'b0;
            tbl_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel_q  <= 1'b0;
            ld_addr_q   <= '0;
            ld_done_q   <= 1'b0;
            tbl_valid_q <= 1'b0;
        end else begin
            bank_sel_q  <= bank_sel_d;
            ld_addr_q   <= ld_addr_d;
            ld_done_q   <= ld_done_d;
            tbl_valid_q <= tbl_valid_d;
        end
    end

    assign tbl_valid = tbl_valid_q;
    assign ld_done   = ld_done_q;

    always_comb begin
        lookup = '0;
        for (int i = 0; i < LANES; i++) begin
            lookup[i*W +: W] = bank_sel_q ? bank1_q[in_data[i*W +: W]]
                                          : bank0_q[in_data[i*W +: W]];
        end
    end

    assign in_fire = in_valid && in_ready;

`ifdef ODO_SBOX_OREG_EN
    logic               s1_valid_q;
    logic [LANES*W-1:0] s1_data_q;
    logic               s2_valid_q;
    logic [LANES*W-1:0] s2_data_q;
    logic               s2_load;

    // Stage 2 takes stage 1 whenever it is empty or draining; stage 1 refills behind it.
    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !(s1_valid_q && s2_valid_q && !out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            if (s2_load) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s1_data_q;
                end
            end
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                s1_data_q  <= lookup;
            end else if (s2_load) begin
                s1_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_data  = s2_data_q;
`else
    logic               o_valid_q;
    logic [LANES*W-1:0] o_data_q;

    assign in_ready = !o_valid_q || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
        end else if (in_fire) begin
            o_valid_q <= 1'b1;
            o_data_q  <= lookup;
        end else if (out_ready) begin
            o_valid_q <= 1'b0;
        end
    end

    assign out_valid = o_valid_q;
    assign out_data  = o_data_q;
`endif

endmodule

// File: tb/tb_odo_sbox_lanes.sv
// Self-checking bench for odo_sbox_lanes (default build, latency 1): scoreboard of
// expected lookups from a table model, plus direct checks of control outputs.
module tb_odo_sbox_lanes;

    localparam int W     = 6;
    localparam int LANES = 4;
    localparam int DW    = LANES * W;
    localparam int DEPTH = 1 << W;

    typedef struct {
        logic          chk;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_valid;
    logic [W-1:0]  ld_data;
    logic          swap;
    logic          tbl_valid;
    logic          ld_done;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    odo_sbox_lanes #(.W(W), .LANES(LANES)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .swap      (swap),
        .tbl_valid (tbl_valid),
        .ld_done   (ld_done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] splat(input logic [W-1:0] v);
        logic [DW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*W +: W] = v;
        return r;
    endfunction

    // Reference model of the table banks and load/swap control.
    logic [W-1:0] m_bank [2][DEPTH];
    logic         m_sel, m_done, m_tv;
    int           m_addr;
    exp_t         sb_q [$];

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            m_sel  = 1'b0;
            m_done = 1'b0;
            m_tv   = 1'b0;
            m_addr = 0;
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_beat", 64'(out_data), 64'hx);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    if (e.chk) check("sb_lookup", 64'(out_data), 64'(e.data));
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.chk = m_tv;
                for (int i = 0; i < LANES; i++)
                    e.data[i*W +: W] = m_bank[m_sel][in_data[i*W +: W]];
                sb_q.push_back(e);
            end
            begin
                logic full;
                full = m_done || (ld_valid && m_addr == DEPTH - 1);
                if (ld_valid) begin
                    m_bank[!m_sel][m_addr] = ld_data;
                    m_addr = (m_addr + 1) % DEPTH;
                end
                m_done = full;
                if (swap && full) begin
                    m_sel  = !m_sel;
                    m_done = 1'b0;
                    m_addr = 0;
                    m_tv   = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] beat_a;
        logic [DW-1:0] beat_b;
        logic          acc;
        rst = 1'b1; ld_valid = 1'b0; ld_data = '0; swap = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step(); step();
        check("rst_tbl_valid", 64'(tbl_valid), 64'd0);
        check("rst_ld_done",   64'(ld_done),   64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        rst = 1'b0;

        // Identity table, swap, first lookup.
        for (int a = 0; a < DEPTH; a++) begin
            ld_valid = 1'b1; ld_data = W'(a); step();
        end
        ld_valid = 1'b0;
        check("ident_ld_done", 64'(ld_done), 64'd1);
        swap = 1'b1; step(); swap = 1'b0;
        check("ident_tbl_valid", 64'(tbl_valid), 64'd1);
        check("ident_ld_done_clr", 64'(ld_done), 64'd0);
        in_valid = 1'b1; in_data = {6'h15, 6'h3F, 6'h00, 6'h23}; step();
        in_valid = 1'b0;
        check("ident_out_valid", 64'(out_valid), 64'd1);
        check("ident_out_data", 64'(out_data), 64'({6'h15, 6'h3F, 6'h00, 6'h23}));

        // Half-loaded x^0x3F, premature swap is ignored.
        for (int a = 0; a < 32; a++) begin
            ld_valid = 1'b1; ld_data = W'(a) ^ 6'h3F; step();
        end
        ld_valid = 1'b0;
        check("half_ld_done", 64'(ld_done), 64'd0);
        swap = 1'b1; step(); swap = 1'b0;
        in_valid = 1'b1; in_data = splat(6'h01); step();
        in_valid = 1'b0;
        check("half_swap_ignored", 64'(out_data), 64'(splat(6'h01)));

        // Finish the load under live lookups; swap in the final write cycle.
        for (int a = 32; a < DEPTH; a++) begin
            ld_valid = 1'b1; ld_data = W'(a) ^ 6'h3F;
            in_valid = 1'b1;
            if (a == DEPTH - 1) begin
                swap = 1'b1; in_data = splat(6'h01);
            end else begin
                in_data = DW'($urandom);
            end
            step();
        end
        ld_valid = 1'b0; swap = 1'b0;
        check("swapcyc_beat_old_bank", 64'(out_data), 64'(splat(6'h01)));
        check("swapcyc_ld_done", 64'(ld_done), 64'd0);
        in_data = splat(6'h01); step();
        in_valid = 1'b0;
        check("xor_lookup", 64'(out_data), 64'(splat(6'h3E)));
        step();

        // Backpressure hold and same-cycle release.
        beat_a = {6'h05, 6'h10, 6'h2F, 6'h3A};
        beat_b = {6'h11, 6'h22, 6'h33, 6'h00};
        out_ready = 1'b0; in_valid = 1'b1; in_data = beat_a; #1;
        check("bp_ready_empty", 64'(in_ready), 64'd1);
        step();
        in_data = beat_b;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_hold_data", 64'(out_data), 64'(beat_a ^ splat(6'h3F)));
            step();
        end
        out_ready = 1'b1; #1;
        check("bp_release_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        check("bp_release_beat", 64'(out_data), 64'(beat_b ^ splat(6'h3F)));

        // Random valid/ready traffic against the scoreboard.
        in_valid = 1'b0;
        for (int c = 0; c < 300; c++) begin
            out_ready = ($urandom_range(3) != 0);
            if (!in_valid || acc) begin
                in_valid = $urandom_range(1);
                in_data  = DW'($urandom);
            end
            #1;
            acc = in_valid && in_ready;
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        // Reset mid-load, then reload a constant table.
        for (int a = 0; a < 40; a++) begin
            ld_valid = 1'b1; ld_data = 6'h11; step();
        end
        ld_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
        check("mid_rst_ld_done", 64'(ld_done), 64'd0);
        check("mid_rst_tbl_valid", 64'(tbl_valid), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        for (int a = 0; a < DEPTH; a++) begin
            ld_valid = 1'b1; ld_data = 6'h2A; step();
        end
        ld_valid = 1'b0;
        swap = 1'b1; step(); swap = 1'b0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; in_data = DW'($urandom); step();
            check("const_lookup", 64'(out_data), 64'(splat(6'h2A)));
        end
        in_valid = 1'b0;
        step(); step();
        check("sb_final_empty", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/odo_sbox_lanes.md
Name: odo_sbox_lanes

Overview:
Parametrised, multi-lane successor to the fixed 6-bit Odo S-box ROM. LANES independent W-bit substitutions share one double-buffered, runtime-loadable table, so a new epoch's S-box can be streamed in while the current one keeps serving lookups. The block sits in the Odo round datapath between the key-mix stage and the permutation stage. It carries a valid/ready stream interface with backpressure.

Parameters:
W, 6, S-box input/output width in bits; table depth is 2^W.
LANES, 4, number of parallel lookups per beat.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous, active-high reset.
ld_valid  in  1  table-load beat valid.
ld_data  in  W  table entry for the current load address.
swap  in  1  one-cycle pulse requesting a bank swap.
tbl_valid  out  1  active bank holds a complete table.
ld_done  out  1  shadow bank fully written since last swap.
in_valid  in  1  lookup beat valid.
in_ready  out  1  block accepts lookup beat.
in_data  in  LANES*W  lane i occupies bits [i*W +: W].
out_valid  out  1  result beat valid.
out_ready  in  1  downstream accepts result.
out_data  out  LANES*W  lane i = table[in lane i].

Behaviour:
- Clock is clk. Reset is rst: synchronous, active-high, one clock domain only.
- Two banks of 2^W x W storage. bank_sel selects the active bank for lookups. Loads always write the other (shadow) bank.
- Reset values: bank_sel=0, ld_addr=0, ld_done=0, tbl_valid=0, out_valid=0, out_data=0. Table storage is not reset.
- Load:
  - Each ld_valid cycle writes ld_data to shadow[ld_addr], then ld_addr increments.
  - Writing address 2^W-1 wraps ld_addr to 0 and sets ld_done=1 on the next cycle.
  - Further loads after ld_done overwrite from address 0. ld_done stays 1.
- Swap:
  - swap with ld_done=1: bank_sel toggles, ld_done clears, ld_addr clears, tbl_valid sets, all on the next edge.
  - swap with ld_done=0: ignored, no state change.
  - swap and ld_valid in the same cycle: the write lands in the pre-swap shadow bank and is counted before the swap check. A swap in the cycle that writes entry 2^W-1 is therefore accepted.
- Lookup pipeline, base latency 1:
  - in_ready = !out_valid || out_ready.
  - On in_valid && in_ready, out_data is loaded next cycle with the active-bank lookup of all lanes, and out_valid=1.
  - The bank used is the one active in the accept cycle. A swap in that same cycle does not affect that beat.
  - If out_valid && !out_ready, out_data and out_valid hold stable.
  - Lookups with tbl_valid=0 are accepted. Their data is undefined (X-permitted) and checked by no test.
- Loads never stall lookups; the two proceed concurrently.
- Reset mid-load: ld_addr and ld_done return to 0, and the partial shadow contents are discarded logically. Reset mid-stream drops the in-flight beat.

Optional Feature:
ODO_SBOX_OREG_EN
- Defined: adds a second output register stage, giving latency 2 for timing closure.
  - in_ready = !(stage1 valid && stage2 valid && !out_ready).
  - The pipeline must sustain 1 beat/cycle when out_ready=1.
  - No beat may be lost or duplicated under any out_ready pattern.
- Undefined: single stage as above, latency 1.

Test Plan:
1. Reset with W=6, LANES=4 -> tbl_valid=0, ld_done=0, out_valid=0, out_data=0, in_ready=1.
2. Load 64 entries of identity (data=addr), then pulse swap; send in_data lanes {0x23,0x00,0x3F,0x15} -> one cycle later out_valid=1, out_data={0x23,0x00,0x3F,0x15}, tbl_valid=1.
3. Load 32 entries of x^0x3F, then pulse swap -> swap ignored, bank_sel unchanged. Lookup 0x01 -> 0x01.
4. Complete the load of x^0x3F while issuing lookups -> lookups keep returning identity. After swap, lookup 0x01 -> 0x3E. A beat accepted in the swap cycle returns 0x01.
5. Hold out_ready=0 for 5 cycles after a result -> out_data stable, in_ready=0. Release -> the next beat is accepted in the same cycle.
6. Assert rst after 40 load beats, then reload all 64 entries of constant 0x2A and swap -> every lane returns 0x2A.
